// File: rtl/axi_mem_slave_pkg.sv
// Shared constants for the AXI memory responder: response and burst codes,
// FSM state encodings and the per-beat address step helper.
package axi_mem_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int BEAT_BYTES = 8;
    localparam int BEAT_SHIFT = 3;

    typedef logic [0:0] r_state_t;
    typedef logic [1:0] w_state_t;

    localparam r_state_t R_IDLE = 1'b0;
    localparam r_state_t R_DATA = 1'b1;

    localparam w_state_t W_IDLE = 2'b00;
    localparam w_state_t W_DATA = 2'b01;
    localparam w_state_t W_RESP = 2'b10;

    // WRAP is deliberately handled as INCR; only FIXED holds the address.
    function automatic logic [7:0] beat_step(input logic [1:0] burst, input logic [2:0] size);
        beat_step = (burst == BURST_FIXED) ? 8'd0 : (8'd1 << size);
    endfunction

endpackage

// File: rtl/axi_mem_slave_array.sv
// Word-organised SRAM: one byte-strobed synchronous write port and one
// asynchronous read port, so a same-cycle write is seen by the reader next cycle.
module axi_mem_array #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; clearing thousands of words is
    // neither required nor cheap, and it keeps the array mappable to SRAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: independent read (AR/R) and write (AW/W/B) FSMs
// sharing one byte-strobed word array; out-of-range beats answer SLVERR.
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 64,
    parameter int              ID_W   = 4,
    parameter int              DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                axi_ar_valid_i,
    output logic                axi_ar_ready_o,
    input  logic [ID_W-1:0]     axi_ar_id_i,
    input  logic [ADDR_W-1:0]   axi_ar_addr_i,
    input  logic [7:0]          axi_ar_len_i,
    input  logic [2:0]          axi_ar_size_i,
    input  logic [1:0]          axi_ar_burst_i,

    output logic                axi_r_valid_o,
    input  logic                axi_r_ready_i,
    output logic [ID_W-1:0]     axi_r_id_o,
    output logic [DATA_W-1:0]   axi_r_data_o,
    output logic [1:0]          axi_r_resp_o,
    output logic                axi_r_last_o,

    input  logic                axi_aw_valid_i,
    output logic                axi_aw_ready_o,
    input  logic [ID_W-1:0]     axi_aw_id_i,
    input  logic [ADDR_W-1:0]   axi_aw_addr_i,
    input  logic [7:0]          axi_aw_len_i,
    input  logic [2:0]          axi_aw_size_i,
    input  logic [1:0]          axi_aw_burst_i,

    input  logic                axi_w_valid_i,
    output logic                axi_w_ready_o,
    input  logic [DATA_W-1:0]   axi_w_data_i,
    input  logic [DATA_W/8-1:0] axi_w_wstrb_i,
    input  logic                axi_w_last_i,

    output logic                axi_bw_valid_o,
    input  logic                axi_bw_ready_i,
    output logic [ID_W-1:0]     axi_bw_id_o,
    output logic [1:0]          axi_bw_resp_o
);

    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DEPTH * BEAT_BYTES);

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return (a >= BASE) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return off[BEAT_SHIFT +: IDX_W];
    endfunction

    // ---------------- read channel state ----------------
    r_state_t           r_state;
    logic [ID_W-1:0]    r_id;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_len;
    logic [2:0]         r_size;
    logic [1:0]         r_burst;
    logic [7:0]         r_beat;
    logic               r_held;
    logic [DATA_W-1:0]  r_hold_data;

    // ---------------- write channel state ----------------
    w_state_t           w_state;
    logic [ID_W-1:0]    w_id;
    logic [ADDR_W-1:0]  w_addr;
    logic [7:0]         w_len;
    logic [2:0]         w_size;
    logic [1:0]         w_burst;
    logic [7:0]         w_beat;
    logic               w_err;

    logic               r_hit;
    logic               w_hit;
    logic               w_fire;
    logic [DATA_W-1:0]  mem_rdata;
    logic [DATA_W-1:0]  r_beat_data;

    assign r_hit       = addr_hit(r_addr);
    assign w_hit       = addr_hit(w_addr);
    assign w_fire      = (w_state == W_DATA) && axi_w_valid_i;
    assign r_beat_data = r_hit ? mem_rdata : '0;

    axi_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk    (clk),
        .we     (w_fire && w_hit),
        .waddr  (word_idx(w_addr)),
        .wdata  (axi_w_data_i),
        .wstrb  (axi_w_wstrb_i),
        .raddr  (word_idx(r_addr)),
        .rdata  (mem_rdata)
    );

    // Read FSM. A stalled beat is frozen in r_hold_data so a concurrent write
    // to the same word cannot change data the master has not yet taken.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= R_IDLE;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_held      <= 1'b0;
            r_hold_data <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi_ar_valid_i) begin
                        r_id    <= axi_ar_id_i;
                        r_addr  <= axi_ar_addr_i;
                        r_len   <= axi_ar_len_i;
                        r_size  <= axi_ar_size_i;
                        r_burst <= axi_ar_burst_i;
                        r_beat  <= '0;
                        r_held  <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi_r_ready_i) begin
                        r_held <= 1'b0;
                        if (r_beat == r_len) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_addr <= r_addr + ADDR_W'(beat_step(r_burst, r_size));
                        end
                    end else begin
                        r_held <= 1'b1;
                        if (!r_held) begin
                            r_hold_data <= r_beat_data;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM. The error flag is sticky across the burst: any dropped beat,
    // an early wlast, or running past len all end in SLVERR.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi_aw_valid_i) begin
                        w_id    <= axi_aw_id_i;
                        w_addr  <= axi_aw_addr_i;
                        w_len   <= axi_aw_len_i;
                        w_size  <= axi_aw_size_i;
                        w_burst <= axi_aw_burst_i;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_w_valid_i) begin
                        if (!w_hit || (axi_w_last_i ? (w_beat != w_len) : (w_beat == w_len))) begin
                            w_err <= 1'b1;
                        end
                        if (axi_w_last_i) begin
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                            w_addr <= w_addr + ADDR_W'(beat_step(w_burst, w_size));
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bw_ready_i) begin
                        w_err   <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign axi_ar_ready_o = (r_state == R_IDLE);
    assign axi_r_valid_o  = (r_state == R_DATA);
    assign axi_r_id_o     = r_id;
    assign axi_r_data_o   = (r_state != R_DATA) ? '0 : (r_held ? r_hold_data : r_beat_data);
    assign axi_r_resp_o   = ((r_state == R_DATA) && !r_hit) ? RESP_SLVERR : RESP_OKAY;
    assign axi_r_last_o   = (r_state == R_DATA) && (r_beat == r_len);

    assign axi_aw_ready_o = (w_state == W_IDLE);
    assign axi_w_ready_o  = (w_state == W_DATA);
    assign axi_bw_valid_o = (w_state == W_RESP);
    assign axi_bw_id_o    = w_id;
    assign axi_bw_resp_o  = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, backpressure, range
// errors, early wlast, concurrent channels and mid-burst reset.
module tb_axi_mem_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready;
    logic        r_ready, r_valid, b_ready, b_valid, w_last, r_last;
    logic [3:0]  ar_id, aw_id, r_id, b_id;
    logic [31:0] ar_addr, aw_addr;
    logic [7:0]  ar_len, aw_len, w_strb;
    logic [2:0]  ar_size, aw_size;
    logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;
    logic [63:0] w_data, r_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] wr_data [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id_q;
    int          rd_lat;
    logic [1:0]  b_resp_q;
    logic [3:0]  b_id_q;
    logic [63:0] held_ref;

    axi_mem_slave dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .axi_ar_valid_i (ar_valid),
        .axi_ar_ready_o (ar_ready),
        .axi_ar_id_i    (ar_id),
        .axi_ar_addr_i  (ar_addr),
        .axi_ar_len_i   (ar_len),
        .axi_ar_size_i  (ar_size),
        .axi_ar_burst_i (ar_burst),
        .axi_r_valid_o  (r_valid),
        .axi_r_ready_i  (r_ready),
        .axi_r_id_o     (r_id),
        .axi_r_data_o   (r_data),
        .axi_r_resp_o   (r_resp),
        .axi_r_last_o   (r_last),
        .axi_aw_valid_i (aw_valid),
        .axi_aw_ready_o (aw_ready),
        .axi_aw_id_i    (aw_id),
        .axi_aw_addr_i  (aw_addr),
        .axi_aw_len_i   (aw_len),
        .axi_aw_size_i  (aw_size),
        .axi_aw_burst_i (aw_burst),
        .axi_w_valid_i  (w_valid),
        .axi_w_ready_o  (w_ready),
        .axi_w_data_i   (w_data),
        .axi_w_wstrb_i  (w_strb),
        .axi_w_last_i   (w_last),
        .axi_bw_valid_o (b_valid),
        .axi_bw_ready_i (b_ready),
        .axi_bw_id_o    (b_id),
        .axi_bw_resp_o  (b_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] id,
                               input int nbeats, input logic [7:0] strb);
        int n;
        aw_addr = addr; aw_len = len; aw_size = 3'd3; aw_burst = burst; aw_id = id;
        aw_valid = 1'b1;
        n = 0;
        while (!aw_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("aw_timeout", 0, 1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            w_valid = 1'b1; w_data = wr_data[i]; w_strb = strb; w_last = (i == nbeats - 1);
            n = 0;
            while (!w_ready && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) check("w_timeout", 0, 1);
            @(posedge clk); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        b_ready = 1'b1;
        n = 0;
        while (!b_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("b_timeout", 0, 1);
        b_resp_q = b_resp; b_id_q = b_id;
        @(posedge clk); #1;
        b_ready = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] id);
        int n;
        ar_addr = addr; ar_len = len; ar_size = 3'd3; ar_burst = burst; ar_id = id;
        ar_valid = 1'b1;
        n = 0;
        while (!ar_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("ar_timeout", 0, 1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!r_valid && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) check("r_timeout", 0, 1);
            if (i == 0) rd_lat = n;
            rd_data[i] = r_data; rd_resp[i] = r_resp; rd_last[i] = r_last; rd_id_q = r_id;
            @(posedge clk); #1;
        end
        r_ready = 1'b0;
    endtask

    initial begin
        {ar_valid, aw_valid, w_valid, r_ready, b_ready, w_last} = '0;
        {ar_id, aw_id, ar_addr, aw_addr, ar_len, aw_len} = '0;
        {ar_size, aw_size, ar_burst, aw_burst, w_strb, w_data} = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", ar_ready, 1);
        check("rst_awready", aw_ready, 1);
        check("rst_wready",  w_ready,  0);
        check("rst_rvalid",  r_valid,  0);
        check("rst_bvalid",  b_valid,  0);
        check("rst_rdata",   r_data,   0);
        check("rst_rid",     r_id,     0);
        check("rst_rlast",   r_last,   0);
        check("rst_bresp",   b_resp,   0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // W beats before AW are not accepted.
        w_valid = 1'b1; w_last = 1'b1;
        @(posedge clk); #1;
        check("w_before_aw_0", w_ready, 0);
        @(posedge clk); #1;
        check("w_before_aw_1", w_ready, 0);
        w_valid = 1'b0; w_last = 1'b0;

        // Single read after preloading word 0.
        wr_data[0] = 64'h1122334455667788;
        write_burst(32'h8000_0000, 8'd0, 2'b01, 4'd1, 1, 8'hFF);
        check("pre_bresp", b_resp_q, 2'b00);
        check("pre_bid",   b_id_q,   4'd1);
        read_burst(32'h8000_0000, 8'd0, 2'b01, 4'd3);
        check("single_lat",  rd_lat,     0);
        check("single_data", rd_data[0], 64'h1122334455667788);
        check("single_rid",  rd_id_q,    4'd3);
        check("single_last", rd_last[0], 1);
        check("single_resp", rd_resp[0], 2'b00);
        check("single_idle", r_valid,    0);
        check("single_arrdy", ar_ready,  1);

        // INCR write then read, four beats.
        for (int i = 0; i < 4; i++) wr_data[i] = 64'(i + 1);
        write_burst(32'h8000_0010, 8'd3, 2'b01, 4'd5, 4, 8'hFF);
        check("incr_bresp", b_resp_q, 2'b00);
        check("incr_bid",   b_id_q,   4'd5);
        read_burst(32'h8000_0010, 8'd3, 2'b01, 4'd6);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_data%0d", i), rd_data[i], 64'(i + 1));
            check($sformatf("incr_last%0d", i), rd_last[i], (i == 3) ? 1 : 0);
        end

        // Strobed write over a cleared word, then read under backpressure.
        wr_data[0] = 64'h0;
        write_burst(32'h8000_0000, 8'd0, 2'b01, 4'd2, 1, 8'hFF);
        wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        write_burst(32'h8000_0000, 8'd0, 2'b01, 4'd2, 1, 8'h0F);
        check("strb_bresp", b_resp_q, 2'b00);
        ar_addr = 32'h8000_0000; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01; ar_id = 4'd7;
        ar_valid = 1'b1; r_ready = 1'b0;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        held_ref = 64'h0000_0000_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid%0d", i), r_valid, 1);
            check($sformatf("bp_data%0d", i),  r_data,  held_ref);
            @(posedge clk); #1;
        end
        r_ready = 1'b1;
        check("bp_data_rdy", r_data, held_ref);
        @(posedge clk); #1;
        check("bp_single", r_valid, 0);
        r_ready = 1'b0;

        // Below BASE with FIXED: both beats out of range.
        read_burst(32'h7FFF_FFF8, 8'd1, 2'b00, 4'd4);
        check("oor_r_d0", rd_data[0], 0);
        check("oor_r_e0", rd_resp[0], 2'b10);
        check("oor_r_d1", rd_data[1], 0);
        check("oor_r_e1", rd_resp[1], 2'b10);
        check("oor_r_l1", rd_last[1], 1);

        // Last word in range, next INCR beat falls off the top.
        wr_data[0] = 64'hCAFE_F00D_0BAD_BEEF;
        write_burst(32'h8000_7FF8, 8'd0, 2'b01, 4'd0, 1, 8'hFF);
        read_burst(32'h8000_7FF8, 8'd1, 2'b01, 4'd0);
        check("top_d0", rd_data[0], 64'hCAFE_F00D_0BAD_BEEF);
        check("top_e0", rd_resp[0], 2'b00);
        check("top_d1", rd_data[1], 0);
        check("top_e1", rd_resp[1], 2'b10);

        // Out-of-range write aliases word 0 in the low index bits; must be dropped.
        wr_data[0] = 64'hDEAD_DEAD_DEAD_DEAD;
        write_burst(32'h9000_0000, 8'd0, 2'b01, 4'd9, 1, 8'hFF);
        check("oor_w_bresp", b_resp_q, 2'b10);
        check("oor_w_bid",   b_id_q,   4'd9);
        read_burst(32'h8000_0000, 8'd0, 2'b01, 4'd0);
        check("oor_w_mem", rd_data[0], 64'h0000_0000_FFFF_FFFF);

        // Early wlast: len=3 but only two beats.
        wr_data[0] = 64'hAAAA; wr_data[1] = 64'hBBBB;
        write_burst(32'h8000_0040, 8'd3, 2'b01, 4'd8, 2, 8'hFF);
        check("early_bresp", b_resp_q, 2'b10);
        read_burst(32'h8000_0040, 8'd1, 2'b01, 4'd0);
        check("early_d0", rd_data[0], 64'hAAAA);
        check("early_d1", rd_data[1], 64'hBBBB);

        // FIXED write keeps hammering one word.
        wr_data[0] = 64'h1111; wr_data[1] = 64'h2222;
        write_burst(32'h8000_0080, 8'd1, 2'b00, 4'd1, 2, 8'hFF);
        check("fixed_bresp", b_resp_q, 2'b00);
        read_burst(32'h8000_0080, 8'd1, 2'b00, 4'd0);
        check("fixed_d0", rd_data[0], 64'h2222);
        check("fixed_d1", rd_data[1], 64'h2222);

        // Overlapping read and write bursts on disjoint regions.
        for (int i = 0; i < 4; i++) wr_data[i] = 64'(i + 5);
        fork
            write_burst(32'h8000_0100, 8'd3, 2'b01, 4'd10, 4, 8'hFF);
            read_burst(32'h8000_0010, 8'd3, 2'b01, 4'd11);
        join
        check("conc_bresp", b_resp_q, 2'b00);
        check("conc_rid",   rd_id_q,  4'd11);
        check("conc_r0",    rd_data[0], 64'd1);
        check("conc_r3",    rd_data[3], 64'd4);
        read_burst(32'h8000_0100, 8'd3, 2'b01, 4'd0);
        check("conc_w0", rd_data[0], 64'd5);
        check("conc_w3", rd_data[3], 64'd8);

        // Reset in the middle of an 8-beat read.
        ar_addr = 32'h8000_0010; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'b01; ar_id = 4'd12;
        ar_valid = 1'b1;
        @(posedge clk); #1;
        ar_valid = 1'b0; r_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_pre_valid", r_valid, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rvalid",  r_valid,  0);
        check("mid_arready", ar_ready, 1);
        check("mid_awready", aw_ready, 1);
        check("mid_rid",     r_id,     0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("mid_quiet%0d", i), r_valid, 0);
        end
        r_ready = 1'b0;

        // Memory survives reset.
        read_burst(32'h8000_0010, 8'd0, 2'b01, 4'd0);
        check("mem_kept", rd_data[0], 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
